// File: rtl/step_gen_array.sv
// step_gen_array -- N_CH independent step-pulse generators with signed
// position tracking, missed-strobe accounting and a global position snapshot.
// Each channel launches on a strobe while idle, then counts up every cycle;
// the step pulse is high while the previous count lies in [pre_n, pulse_n),
// and the channel ends once the count reaches post_n (or saturates).
// Optional feature: define STEP_GEN_QUEUE_EN to add a one-deep pending
// request slot per channel so a strobe arriving mid-pulse is deferred rather
// than dropped. With the macro undefined, no queue logic is built.
module step_gen_array #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        pre_n,
  input  logic [CNT_W-1:0]        pulse_n,
  input  logic [CNT_W-1:0]        post_n,
  input  logic [N_CH-1:0]         step_stb,
  input  logic [N_CH-1:0]         step_dir,
  input  logic [N_CH-1:0]         invert_dir,
  input  logic [N_CH-1:0]         set_x,
  input  logic [POS_W-1:0]        x_val,
  input  logic                    hold,
  input  logic                    clr_missed,
  output logic [N_CH-1:0]         step,
  output logic [N_CH-1:0]         dir,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         missed,
  output logic [8*N_CH-1:0]       missed_cnt,
  output logic [POS_W*N_CH-1:0]   x,
  output logic [POS_W*N_CH-1:0]   x_hold
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [POS_W-1:0] X_ONE   = POS_W'(1);
  localparam logic [7:0]       MCNT_MAX = 8'hFF;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             missed_q, missed_d;
    logic [7:0]       mcnt_q, mcnt_d;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] xh_q, xh_d;

    logic active;       // channel is mid-pulse this cycle
    logic term;         // this is the last active cycle
    logic launch;       // a request starts a new pulse next cycle
    logic launch_sdir;  // raw direction of the launching request
    logic launch_inv;   // polarity flip of the launching request
    logic drop;         // strobe discarded and reported as missed

`ifdef STEP_GEN_QUEUE_EN
    logic pend_q, pend_d;
    logic pend_sdir_q, pend_sdir_d;
    logic pend_inv_q, pend_inv_d;
`endif

    // Decide whether this cycle's strobe launches, waits in the slot, or is dropped.
    always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
      active      = (cnt_q != '0);
      term        = active && ((cnt_q >= post_n) || (&cnt_q));
      launch      = 1'b0;
      launch_sdir = step_dir[i];
      launch_inv  = invert_dir[i];
      drop        = 1'b0;
`ifdef STEP_GEN_QUEUE_EN
      pend_d      = pend_q;
      pend_sdir_d = pend_sdir_q;
      pend_inv_d  = pend_inv_q;
      if (!active) begin
        launch = step_stb[i];
      end else if (term) begin
        if (pend_q) begin
          // Pending request launches; a same-cycle strobe takes the freed slot.
          launch      = 1'b1;
          launch_sdir = pend_sdir_q;
          launch_inv  = pend_inv_q;
          pend_d      = step_stb[i];
          pend_sdir_d = step_dir[i];
          pend_inv_d  = invert_dir[i];
        end else begin
          // Empty slot: the strobe is queued and leaves it immediately.
          launch = step_stb[i];
        end
      end else if (step_stb[i]) begin
        if (pend_q) begin
          drop = 1'b1;
        end else begin
          pend_d      = 1'b1;
          pend_sdir_d = step_dir[i];
          pend_inv_d  = invert_dir[i];
        end
      end
`else
      launch = step_stb[i] && !active;
      drop   = step_stb[i] && active;
`endif
    end

    // Next-state datapath: counter, pulse, direction, position and missed count.
    always_comb begin
      cnt_d = '0;
      if (launch) begin
        cnt_d = CNT_ONE;
      end else if (active && !term) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      busy_d = (cnt_d != '0);
      step_d = active && (cnt_q >= pre_n) && (cnt_q < pulse_n);
      dir_d  = launch ? (launch_sdir ^ launch_inv) : dir_q;

      // Position follows the raw direction; a load overrides the step update.
      x_d = x_q;
      if (launch) begin
        x_d = launch_sdir ? (x_q - X_ONE) : (x_q + X_ONE);
      end
      if (set_x[i]) begin
        x_d = x_val;
      end
      xh_d = hold ? x_q : xh_q;

      missed_d = drop;
      mcnt_d   = mcnt_q;
      if (clr_missed) begin
        mcnt_d = '0;
      end else if (drop && (mcnt_q != MCNT_MAX)) begin
        mcnt_d = mcnt_q + 8'd1;
      end
    end

    // State registers; reset clears everything and overrides all requests.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
        cnt_q    <= '0;
        step_q   <= 1'b0;
        dir_q    <= 1'b0;
        busy_q   <= 1'b0;
        missed_q <= 1'b0;
        mcnt_q   <= '0;
        x_q      <= '0;
        xh_q     <= '0;
      end else begin
        cnt_q    <= cnt_d;
        step_q   <= step_d;
        dir_q    <= dir_d;
        busy_q   <= busy_d;
        missed_q <= missed_d;
        mcnt_q   <= mcnt_d;
        x_q      <= x_d;
        xh_q     <= xh_d;
      end
    end

`ifdef STEP_GEN_QUEUE_EN
    // Pending-slot registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        pend_q      <= 1'b0;
        pend_sdir_q <= 1'b0;
        pend_inv_q  <= 1'b0;
      end else begin
        pend_q      <= pend_d;
        pend_sdir_q <= pend_sdir_d;
        pend_inv_q  <= pend_inv_d;
      end
    end
`endif

    assign step[i]                     = step_q;
    assign dir[i]                      = dir_q;
    assign busy[i]                     = busy_q;
    assign missed[i]                   = missed_q;
    assign missed_cnt[i*8 +: 8]        = mcnt_q;
    assign x[i*POS_W +: POS_W]         = x_q;
    assign x_hold[i*POS_W +: POS_W]    = xh_q;
  end

endmodule

// File: tb/tb_step_gen_array.sv
// Testbench for step_gen_array: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model through a scoreboard.
`timescale 1ns/1ps
module tb_step_gen_array;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 16;
  localparam int POS_W   = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef STEP_GEN_QUEUE_EN
  localparam int QDEPTH = 1;
`else
  localparam int QDEPTH = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CNT_W-1:0]      pre_n, pulse_n, post_n;
  logic [N_CH-1:0]       step_stb, step_dir, invert_dir, set_x;
  logic [POS_W-1:0]      x_val;
  logic                  hold, clr_missed;
  logic [N_CH-1:0]       step, dir, busy, missed;
  logic [8*N_CH-1:0]     missed_cnt;
  logic [POS_W*N_CH-1:0] x, x_hold;

  step_gen_array #(.N_CH(N_CH), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk(clk), .reset(reset),
    .pre_n(pre_n), .pulse_n(pulse_n), .post_n(post_n),
    .step_stb(step_stb), .step_dir(step_dir), .invert_dir(invert_dir),
    .set_x(set_x), .x_val(x_val), .hold(hold), .clr_missed(clr_missed),
    .step(step), .dir(dir), .busy(busy), .missed(missed),
    .missed_cnt(missed_cnt), .x(x), .x_hold(x_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0]       step;
    logic [N_CH-1:0]       dir;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       missed;
    logic [8*N_CH-1:0]     mcnt;
    logic [POS_W*N_CH-1:0] x;
    logic [POS_W*N_CH-1:0] xh;
  } obs_t;

  typedef struct {
    bit sdir;
    bit inv;
  } req_t;

  obs_t exp_q[$];

  // Behavioural model state: cycles elapsed in the pulse, waiting requests.
  int               m_cnt  [N_CH];
  bit               m_step [N_CH];
  bit               m_dir  [N_CH];
  bit               m_miss [N_CH];
  int               m_mcnt [N_CH];
  logic [POS_W-1:0] m_x    [N_CH];
  logic [POS_W-1:0] m_xh   [N_CH];
  req_t             m_pend [N_CH][$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    obs_t e;
    for (int i = 0; i < N_CH; i++) begin
      bit   act, ending, start, miss;
      req_t r, nw;
      if (reset) begin
        m_cnt[i]  = 0;
        m_step[i] = 0;
        m_dir[i]  = 0;
        m_miss[i] = 0;
        m_mcnt[i] = 0;
        m_x[i]    = '0;
        m_xh[i]   = '0;
        m_pend[i].delete();
      end else begin
        act     = (m_cnt[i] != 0);
        ending  = act && ((m_cnt[i] >= int'(post_n)) || (m_cnt[i] == CNT_MAX));
        start   = 0;
        miss    = 0;
        r.sdir  = 0;
        r.inv   = 0;
        nw.sdir = step_dir[i];
        nw.inv  = invert_dir[i];
        m_step[i] = act && (m_cnt[i] >= int'(pre_n)) && (m_cnt[i] < int'(pulse_n));
        if (!act) begin
          if (step_stb[i]) begin start = 1; r = nw; end
        end else if (ending && QDEPTH > 0) begin
          if (m_pend[i].size() > 0) begin
            start = 1;
            r = m_pend[i].pop_front();
            if (step_stb[i]) m_pend[i].push_back(nw);
          end else if (step_stb[i]) begin
            start = 1;
            r = nw;
          end
        end else if (step_stb[i]) begin
          if (m_pend[i].size() < QDEPTH) m_pend[i].push_back(nw);
          else miss = 1;
        end
        if (start) m_cnt[i] = 1;
        else if (act && !ending) m_cnt[i] = m_cnt[i] + 1;
        else m_cnt[i] = 0;
        if (hold) m_xh[i] = m_x[i];
        if (start) begin
          m_dir[i] = r.sdir ^ r.inv;
          m_x[i]   = r.sdir ? (m_x[i] - 1) : (m_x[i] + 1);
        end
        if (set_x[i]) m_x[i] = x_val;
        m_miss[i] = miss;
        if (clr_missed) m_mcnt[i] = 0;
        else if (miss && m_mcnt[i] < 255) m_mcnt[i] = m_mcnt[i] + 1;
      end
      e.step[i]               = m_step[i];
      e.dir[i]                = m_dir[i];
      e.busy[i]               = (m_cnt[i] != 0);
      e.missed[i]             = m_miss[i];
      e.mcnt[i*8 +: 8]        = 8'(m_mcnt[i]);
      e.x[i*POS_W +: POS_W]   = m_x[i];
      e.xh[i*POS_W +: POS_W]  = m_xh[i];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every clock the DUT presents a new output set; compare it.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("step",       step,       e.step);
        check("dir",        dir,        e.dir);
        check("busy",       busy,       e.busy);
        check("missed",     missed,     e.missed);
        check("missed_cnt", missed_cnt, e.mcnt);
        check("x",          x,          e.x);
        check("x_hold",     x_hold,     e.xh);
      end
    end
  end

  // Drive one cycle of the current inputs, then clear the one-shot inputs.
  task automatic apply();
    model_step();
    @(posedge clk);
    #1;
    step_stb   = '0;
    set_x      = '0;
    hold       = 1'b0;
    clr_missed = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply();
    reset = 1'b0;
  endtask

  logic [POS_W-1:0] saved_x [N_CH];

  initial begin
    reset = 1'b1; pre_n = '0; pulse_n = '0; post_n = '0;
    step_stb = '0; step_dir = '0; invert_dir = '0; set_x = '0;
    x_val = '0; hold = 1'b0; clr_missed = 1'b0;
    apply();
    apply();
    reset = 1'b0;

    // Single pulse: busy 1-8, step 3-5, x=1, re-strobe accepted at cycle 9.
    pre_n = 16'd2; pulse_n = 16'd5; post_n = 16'd8;
    step_stb[0] = 1'b1; step_dir[0] = 1'b0;
    apply();
    check("launch_x", x[POS_W-1:0], 1);
    check("launch_busy", busy[0], 1);
    idle(7);
    check("busy_last", busy[0], 1);
    apply();
    check("busy_end", busy[0], 0);
    step_stb[0] = 1'b1;
    apply();
    check("restrobe_x", x[POS_W-1:0], 2);
    idle(12);

    // Strobe at cycle 0 and cycle 4.
    do_reset();
    step_stb[0] = 1'b1;
    apply();
    idle(3);
    step_stb[0] = 1'b1;
    apply();
`ifndef STEP_GEN_QUEUE_EN
    check("miss_flag", missed[0], 1);
    check("miss_cnt1", missed_cnt[7:0], 1);
`endif
    check("miss_x", x[POS_W-1:0], 1);
    idle(12);

    // Negative raw direction with inverted polarity, then load vs step.
    do_reset();
    step_dir[0] = 1'b1; invert_dir[0] = 1'b1; step_stb[0] = 1'b1;
    apply();
    check("neg_x", x[POS_W-1:0], 32'hFFFF_FFFF);
    check("neg_dir", dir[0], 0);
    idle(10);
    step_stb[0] = 1'b1; set_x[0] = 1'b1; x_val = 32'd100;
    apply();
    check("setx_x", x[POS_W-1:0], 100);
    idle(10);
    step_dir = '0; invert_dir = '0;

    // 300 strobes on a long pulse saturate ch2, then clear beats a concurrent miss.
    do_reset();
    post_n = 16'd1000;
    for (int k = 0; k < 300; k++) begin
      step_stb[2] = 1'b1;
      step_dir[2] = 1'($urandom_range(0, 1));
      apply();
    end
    check("mcnt_sat", missed_cnt[23:16], 255);
    step_stb[2] = 1'b1; clr_missed = 1'b1;
    apply();
    check("mcnt_clr", missed_cnt[23:16], 0);
    step_dir = '0;

    // All channels strobe with hold, then reset mid-pulse.
    do_reset();
    post_n = 16'd8;
    for (int i = 0; i < N_CH; i++) begin
      saved_x[i] = $urandom;
      x_val = saved_x[i];
      set_x[i] = 1'b1;
      apply();
    end
    step_stb = '1; hold = 1'b1; step_dir = 4'b0101;
    apply();
    for (int i = 0; i < N_CH; i++) check("hold_snap", x_hold[i*POS_W +: POS_W], saved_x[i]);
    check("all_busy", busy, 4'hF);
    idle(3);
    reset = 1'b1;
    apply();
    reset = 1'b0;
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_x", x, 0);
    check("rst_xhold", x_hold, 0);
    check("rst_mcnt", missed_cnt, 0);

    // Randomized traffic with occasional mid-pulse timing changes and resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0 || k == 0) begin
        pre_n   = CNT_W'($urandom_range(0, 6));
        pulse_n = CNT_W'($urandom_range(0, 9));
        post_n  = CNT_W'($urandom_range(0, 14));
      end
      for (int i = 0; i < N_CH; i++) begin
        step_stb[i]   = ($urandom_range(0, 3) == 0);
        step_dir[i]   = 1'($urandom_range(0, 1));
        invert_dir[i] = 1'($urandom_range(0, 1));
        set_x[i]      = ($urandom_range(0, 31) == 0);
      end
      x_val      = $urandom;
      hold       = ($urandom_range(0, 9) == 0);
      clr_missed = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      apply();
    end
    reset = 1'b0;
    idle(20);

    // Let the monitor drain the scoreboard, bounded in time.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/step_gen_array.md
STEP_GEN_ARRAY -- requirements
Module: step_gen_array

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent step channels.
REQ-002 SHALL have parameter CNT_W, default 16, width of pulse timing counters and timing inputs.
REQ-003 SHALL have parameter POS_W, default 32, width of signed position registers.
REQ-004 SHALL have ports, channel i in bits [i] or slice [i*POS_W +: POS_W]:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pre_n, pulse_n, post_n  in  CNT_W each  shared timing thresholds
- step_stb, step_dir, invert_dir  in  N_CH each  step request, raw direction (1 = negative), output polarity flip
- set_x  in  N_CH  load position
- x_val  in  POS_W  shared signed load value
- hold  in  1  global position snapshot strobe
- clr_missed  in  1  clear all missed counters
- step, dir, busy, missed  out  N_CH each  step pulse, registered direction, channel active, one-cycle missed-strobe flag
- missed_cnt  out  8*N_CH  saturating missed counters
- x, x_hold  out  POS_W*N_CH each  signed live position, snapshot

Function
REQ-005 Each channel SHALL hold a CNT_W counter cnt; cnt==0 is IDLE, cnt!=0 is ACTIVE; busy[i] = (cnt!=0), registered.
REQ-006 A strobe in IDLE at cycle T SHALL launch: cnt=1, dir=step_dir^invert_dir, x decremented if step_dir=1 else incremented (raw step_dir, POS_W two's-complement wrap), all visible at T+1.
REQ-007 In ACTIVE, cnt SHALL increment each cycle; step at cycle k+1 = (pre_n <= cnt_k < pulse_n), unsigned; otherwise step=0.
REQ-008 A channel SHALL terminate when cnt >= post_n or cnt is all-ones; cnt returns to 0 the next cycle; post_n <= 1 gives one ACTIVE cycle.
REQ-009 dir SHALL change only at launch and hold between steps.
REQ-010 Without a queue (REQ-019), a strobe during ACTIVE SHALL be dropped and missed[i] pulsed at the next cycle.
REQ-011 missed_cnt[i] SHALL increment on each missed pulse, saturate at 255, clear on clr_missed; clr_missed wins over a same-cycle increment.
REQ-012 set_x[i] SHALL load x_val into x[i] next cycle, overriding a same-cycle step update; the step pulse still runs.
REQ-013 hold SHALL copy all channels' current registered x (pre-update value of that cycle) into x_hold in the same cycle.
REQ-014 Channels SHALL be fully independent; simultaneous strobes on all channels SHALL all launch in the same cycle.
REQ-015 Timing inputs SHALL be sampled every cycle; changes mid-pulse take effect immediately.

Reset
REQ-016 reset SHALL force cnt, step, dir, busy, missed, missed_cnt, x, x_hold and any queue state to 0 on the next edge.
REQ-017 reset SHALL take priority over strobe, set_x, hold and clr_missed; reset mid-pulse aborts it with step low next cycle.
REQ-018 Strobes asserted during reset SHALL be ignored and not counted as missed.

Configuration
REQ-019 Macro STEP_GEN_QUEUE_EN, when defined, SHALL add a one-deep pending slot per channel storing step_dir and invert_dir.
- A strobe during ACTIVE with the slot empty SHALL be queued, with no missed flag.
- On the terminating cycle, a queued entry SHALL launch as in REQ-006, applying its x update and dir at the next cycle; a same-cycle new strobe SHALL take the freed slot.
- A strobe during ACTIVE with the slot full, other than on the terminating cycle, SHALL be dropped and flagged missed.
- x SHALL update at launch, not at queue time.
REQ-020 Without STEP_GEN_QUEUE_EN, no queue logic SHALL exist and REQ-010 SHALL apply.

Verification
REQ-021 pre=2, pulse=5, post=8, ch0 strobe at cycle 0, dir=0 -> busy cycles 1-8, step high cycles 3-5, x 0->1 at cycle 1, new strobe accepted at cycle 9.
REQ-022 Same timing, strobe at cycle 0 and cycle 4, no queue -> missed[0] at cycle 5, missed_cnt=1, x=1. With queue -> second launch at cycle 9, x=2, no missed.
REQ-023 step_dir=1, invert_dir=1, x=0 -> x=-1 (0xFFFFFFFF), dir=0; set_x with x_val=100 same cycle as strobe -> x=100.
REQ-024 300 missed strobes on ch2 -> missed_cnt[2]=255; clr_missed with a concurrent miss -> 0.
REQ-025 All 4 channels strobe, hold same cycle -> x_hold equals pre-step x on all channels; reset at cycle 4 -> all outputs 0 at cycle 5.
